// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way set-associative cache: FSM states,
// default geometry and the tag-width helper.
package cache_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int INDEX_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MEM_RD = 2'd1,
        ST_MEM_WR = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    function automatic int tag_width(input int addr_w, input int index_w);
        return addr_w - index_w;
    endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: per-set valid/tag/data, synchronous write at the
// lookup index, single-cycle clear of every valid bit, combinational lookup.
module cache_way
    import cache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int TAG_W   = tag_width(ADDR_W_DEF, INDEX_W_DEF),
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [INDEX_W-1:0] idx,
    input  logic [TAG_W-1:0]   tag,
    input  logic               we,
    input  logic [DATA_W-1:0]  wdata,
    output logic               valid,
    output logic               hit,
    output logic [DATA_W-1:0]  rdata
);

    localparam int SETS = 2 ** INDEX_W;

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   valid_d;
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [DATA_W-1:0] data_mem [SETS];

    always_comb begin
        valid_d = valid_q;
        if (clr) begin
            valid_d = '0;
        end else if (we) begin
            valid_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data carry no reset; valid_q alone decides whether an entry counts.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= wdata;
        end
    end

    assign valid = valid_q[idx];
    assign hit   = valid_q[idx] && (tag_mem[idx] == tag);
    assign rdata = data_mem[idx];

endmodule

// File: rtl/cache_2way.sv
// 2-way set-associative write-through, no-write-allocate cache with LRU,
// flush and a req/ack memory port. Define CACHE_STATS_EN for hit/miss counters.
module cache_2way
    import cache_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_miss,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int TAG_W = tag_width(ADDR_W, INDEX_W);
    localparam int SETS  = 2 ** INDEX_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              miss_q, miss_d;
    logic [SETS-1:0]   lru_q, lru_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_miss_q, resp_miss_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_wr_q, mem_wr_d;

    logic [ADDR_W-1:0]  lk_addr;
    logic [INDEX_W-1:0] lk_index;
    logic [TAG_W-1:0]   lk_tag;
    logic [1:0]         way_hit;
    logic [1:0]         way_valid;
    logic [1:0]         way_we;
    logic [DATA_W-1:0]  way_rdata [2];
    logic [DATA_W-1:0]  way_wdata;
    logic               way_clr;
    logic               any_hit;
    logic               hit_way;
    logic               victim;
    logic               accept;

    // New requests are looked up straight from the port; fills use the latched address.
    assign lk_addr   = (state_q == ST_IDLE) ? req_addr : addr_q;
    assign lk_index  = lk_addr[INDEX_W-1:0];
    assign lk_tag    = lk_addr[ADDR_W-1:INDEX_W];
    assign way_wdata = (state_q == ST_MEM_RD) ? mem_rdata : req_wdata;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_way
            cache_way #(
                .INDEX_W(INDEX_W),
                .TAG_W  (TAG_W),
                .DATA_W (DATA_W)
            ) u_way (
                .clk  (clk),
                .rst  (rst),
                .clr  (way_clr),
                .idx  (lk_index),
                .tag  (lk_tag),
                .we   (way_we[gi]),
                .wdata(way_wdata),
                .valid(way_valid[gi]),
                .hit  (way_hit[gi]),
                .rdata(way_rdata[gi])
            );
        end
    endgenerate

    // A double hit cannot happen in normal use; way 0 wins if it does.
    assign any_hit   = |way_hit;
    assign hit_way   = ~way_hit[0];
    assign victim    = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[lk_index]);
    assign req_ready = (state_q == ST_IDLE) && !flush && !rst;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        miss_d       = miss_q;
        lru_d        = lru_q;
        resp_valid_d = 1'b0;
        resp_miss_d  = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_req_d    = mem_req_q;
        mem_wr_d     = mem_wr_q;
        way_we       = 2'b00;
        way_clr      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    way_clr = 1'b1;
                    lru_d   = '0;
                end else if (accept) begin
                    addr_d = req_addr;
                    miss_d = !any_hit;
                    if (req_wr) begin
                        wdata_d   = req_wdata;
                        state_d   = ST_MEM_WR;
                        mem_req_d = 1'b1;
                        mem_wr_d  = 1'b1;
                        if (any_hit) begin
                            way_we[hit_way] = 1'b1;
                            lru_d[lk_index] = ~hit_way;
                        end
                    end else if (any_hit) begin
                        state_d         = ST_RESP;
                        resp_valid_d    = 1'b1;
                        resp_rdata_d    = way_rdata[hit_way];
                        lru_d[lk_index] = ~hit_way;
                    end else begin
                        state_d   = ST_MEM_RD;
                        mem_req_d = 1'b1;
                        mem_wr_d  = 1'b0;
                    end
                end
            end
            ST_MEM_RD: begin
                if (mem_ack) begin
                    way_we[victim]  = 1'b1;
                    lru_d[lk_index] = ~victim;
                    resp_rdata_d    = mem_rdata;
                    mem_req_d       = 1'b0;
                    state_d         = ST_RESP;
                    resp_valid_d    = 1'b1;
                    resp_miss_d     = miss_q;
                end
            end
            ST_MEM_WR: begin
                if (mem_ack) begin
                    mem_req_d    = 1'b0;
                    mem_wr_d     = 1'b0;
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_miss_d  = miss_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            miss_q       <= 1'b0;
            lru_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_miss_q  <= 1'b0;
            resp_rdata_q <= '0;
            mem_req_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            miss_q       <= miss_d;
            lru_q        <= lru_d;
            resp_valid_q <= resp_valid_d;
            resp_miss_q  <= resp_miss_d;
            resp_rdata_q <= resp_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_wr_q     <= mem_wr_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_miss  = resp_miss_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_wr     = mem_wr_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == ST_RESP) begin
            if (miss_q) begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
            end else begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_2way.sv
// Self-checking bench for cache_2way: directed table, flush/reset sequences
// and random traffic against a recency-list cache model and a memory model.
module tb_cache_2way;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_miss;
    logic        flush;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    always #5 clk = ~clk;

    cache_2way dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_miss (resp_miss),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int txn_no   = 0;
    int sb_hit   = 0;
    int sb_miss  = 0;

    // Memory model: explicit contents, otherwise a hash of the address.
    bit [31:0] backing [bit [31:0]];
    int        ack_delay = 0;
    int        req_seen;
    bit        last_mem_wr;
    bit [31:0] last_mem_addr;
    bit [31:0] last_mem_wdata;

    function automatic bit [31:0] dflt(input bit [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic bit [31:0] mem_value(input bit [31:0] a);
        if (backing.exists(a)) return backing[a];
        return dflt(a);
    endfunction

    // Cache model: per set, resident tags ordered least- to most-recently used.
    bit [23:0] m_tag [256][2];
    int        m_cnt [256];

    function automatic void m_clear();
        for (int s = 0; s < 256; s++) m_cnt[s] = 0;
    endfunction

    function automatic int m_find(input bit [31:0] a);
        int s = int'(a[7:0]);
        for (int i = 0; i < m_cnt[s]; i++)
            if (m_tag[s][i] == a[31:8]) return i;
        return -1;
    endfunction

    function automatic void m_use(input bit [31:0] a, input bit alloc);
        int s = int'(a[7:0]);
        int p = m_find(a);
        bit [23:0] t;
        if (p >= 0) begin
            if (p == 0 && m_cnt[s] == 2) begin
                t = m_tag[s][0];
                m_tag[s][0] = m_tag[s][1];
                m_tag[s][1] = t;
            end
        end else if (alloc) begin
            if (m_cnt[s] == 2) begin
                m_tag[s][0] = m_tag[s][1];
                m_tag[s][1] = a[31:8];
            end else begin
                m_tag[s][m_cnt[s]] = a[31:8];
                m_cnt[s]++;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder: acks ack_delay cycles after seeing mem_req, for one cycle.
    initial begin
        int cnt;
        cnt       = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) req_seen++;
            if (mem_ack) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else if (mem_req && !rst) begin
                if (cnt >= ack_delay) begin
                    mem_ack        = 1'b1;
                    last_mem_wr    = mem_wr;
                    last_mem_addr  = mem_addr;
                    last_mem_wdata = mem_wdata;
                    if (mem_wr) backing[mem_addr] = mem_wdata;
                    else mem_rdata = mem_value(mem_addr);
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic wait_ready();
        int waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("req_ready_idle", req_ready, 1);
    endtask

    task automatic do_req(input bit wr, input bit [31:0] addr, input bit [31:0] wdata,
                          input int delay, input bit exp_miss, input bit [31:0] exp_rdata);
        int k = 0;
        bit got = 1'b0;
        ack_delay = delay;
        wait_ready();
        req_seen       = 0;
        last_mem_wr    = 1'b0;
        last_mem_addr  = '0;
        last_mem_wdata = '0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        while (!got && k < 60) begin
            @(negedge clk);
            k++;
            if (k == 1) req_valid = 1'b0;
            if (resp_valid) got = 1'b1;
        end
        check("resp_valid_seen", got, 1);
        check("resp_latency", k, (!wr && !exp_miss) ? 1 : delay + 2);
        check("resp_miss", resp_miss, exp_miss);
        if (!wr) check("resp_rdata", resp_rdata, exp_rdata);
        if (wr || exp_miss) begin
            check("mem_wr", last_mem_wr, wr);
            check("mem_addr", last_mem_addr, addr);
            if (wr) check("mem_wdata", last_mem_wdata, wdata);
        end else begin
            check("no_mem_req_on_hit", req_seen, 0);
        end
        m_use(addr, !wr);
        if (exp_miss) sb_miss++; else sb_hit++;
        txn_no++;
        $display("txn %0d %s addr=0x%03h wdata=0x%08h miss=%0b rdata=0x%08h latency=%0d",
                 txn_no, wr ? "WR" : "RD", addr, wdata, resp_miss, resp_rdata, k);
    endtask

    task automatic do_flush(input bit [31:0] addr);
        wait_ready();
        flush     = 1'b1;
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = addr;
        #1;
        check("req_ready_flush", req_ready, 0);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_no_mem_req", mem_req, 0);
        check("flush_no_resp", resp_valid, 0);
        m_clear();
        txn_no++;
        $display("txn %0d FLUSH with pending req addr=0x%03h", txn_no, addr);
    endtask

    typedef struct {
        bit        wr;
        bit [31:0] addr;
        bit [31:0] wdata;
        int        delay;
        bit        exp_miss;
        bit [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [13];

    initial begin
        bit [31:0] a;
        bit        w;
        bit [31:0] d;
        bit [7:0]  idx_pool [3];

        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_wdata = '0; flush = 1'b0;
        m_clear();
        backing[32'h010] = 32'hDEAD_BEEF;

        vecs[0]  = '{1'b0, 32'h010, 32'h0,  3, 1'b1, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 32'h010, 32'h0,  0, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 32'h110, 32'h0,  1, 1'b1, dflt(32'h110)};
        vecs[3]  = '{1'b0, 32'h210, 32'h0,  0, 1'b1, dflt(32'h210)};
        vecs[4]  = '{1'b0, 32'h110, 32'h0,  2, 1'b0, dflt(32'h110)};
        vecs[5]  = '{1'b0, 32'h010, 32'h0,  2, 1'b1, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b0, 32'h110, 32'h0,  0, 1'b0, dflt(32'h110)};
        vecs[7]  = '{1'b1, 32'h110, 32'h55, 1, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h110, 32'h0,  0, 1'b0, 32'h55};
        vecs[9]  = '{1'b1, 32'h300, 32'h77, 2, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 32'h300, 32'h0,  0, 1'b1, 32'h77};
        vecs[11] = '{1'b0, 32'h210, 32'h0,  1, 1'b1, dflt(32'h210)};
        vecs[12] = '{1'b0, 32'h010, 32'h0,  0, 1'b1, 32'hDEAD_BEEF};

        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_miss", resp_miss, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
`ifdef CACHE_STATS_EN
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", req_ready, 1);

        for (int i = 0; i < 13; i++)
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].delay,
                   vecs[i].exp_miss, vecs[i].exp_rdata);

        do_flush(32'h110);
        do_req(1'b0, 32'h110, 32'h0, 1, 1'b1, 32'h55);
        do_req(1'b0, 32'h300, 32'h0, 0, 1'b1, 32'h77);
        do_req(1'b0, 32'h210, 32'h0, 2, 1'b1, dflt(32'h210));
`ifdef CACHE_STATS_EN
        @(negedge clk);
        check("stats_hit_directed", hit_cnt, sb_hit);
        check("stats_miss_directed", miss_cnt, sb_miss);
`endif

        idx_pool[0] = 8'h10; idx_pool[1] = 8'h11; idx_pool[2] = 8'h55;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                do_flush(32'h010);
            end else begin
                a = {22'd0, 2'($urandom_range(0, 3)), idx_pool[$urandom_range(0, 2)]};
                w = ($urandom_range(0, 9) < 3);
                d = $urandom;
                do_req(w, a, d, $urandom_range(0, 3), (m_find(a) < 0), mem_value(a));
            end
        end
`ifdef CACHE_STATS_EN
        @(negedge clk);
        check("stats_hit_random", hit_cnt, sb_hit);
        check("stats_miss_random", miss_cnt, sb_miss);
`endif

        // Reset while a read miss waits on memory: request is dropped silently.
        ack_delay = 30;
        wait_ready();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h7EE;
        @(negedge clk);
        req_valid = 1'b0;
        check("midrst_mem_req_up", mem_req, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_mem_req_drop", mem_req, 0);
        check("midrst_ready_in_rst", req_ready, 0);
        check("midrst_no_resp", resp_valid, 0);
        rst = 1'b0;
        m_clear();
        sb_hit  = 0;
        sb_miss = 0;
        @(negedge clk);
        check("midrst_ready_after", req_ready, 1);
        check("midrst_no_resp_after", resp_valid, 0);
        txn_no++;
        $display("txn %0d RST during MEM_RD addr=0x7ee", txn_no);
        do_req(1'b0, 32'h7EE, 32'h0, 1, 1'b1, mem_value(32'h7EE));
        do_req(1'b0, 32'h7EE, 32'h0, 0, 1'b0, mem_value(32'h7EE));
`ifdef CACHE_STATS_EN
        @(negedge clk);
        check("stats_hit_after_rst", hit_cnt, sb_hit);
        check("stats_miss_after_rst", miss_cnt, sb_miss);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
